// File: rtl/mem_responder.sv
// Memory-side responder for the SLC3 MAR/MDR interface.
// Turns a level-held CPU read/write request into one wait-stated access on an
// asynchronous SRAM, or into a single memory-mapped I/O access at IO_ADDR
// (switch input on read, hex display register on write). Completion is
// signalled by a one-cycle R pulse. The request must then drop before another
// access can start.
module mem_responder #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    // Extra strobe cycles beyond one. The legal range is 0..7 because the
    // counter is 3 bits wide.
    parameter int                WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'(16'hFFFF)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] MAR,
    input  logic [DATA_W-1:0] MDR_wdata,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [DATA_W-1:0] SW,
    output logic [DATA_W-1:0] Mem_rdata,
    output logic              R,
    output logic [DATA_W-1:0] hex_out,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [2:0] WS_LAST = 3'(WAIT_STATES);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] hex_q, hex_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              req;

    assign req = Mem_OE | Mem_WE;

    // State register and registered outputs. Reset drops the SRAM strobes
    // immediately, even in the middle of an access.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            hex_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            hex_q   <= hex_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
        end
    end

    // Next-state logic. The strobe values are computed one cycle ahead so that
    // the strobe pins come straight from flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        hex_d   = hex_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    // Sample the address and data once. A write wins when
                    // both request lines are high.
                    addr_d  = MAR;
                    wdata_d = MDR_wdata;
                    wr_d    = Mem_WE;
                    cnt_d   = 3'd0;
                    if (MAR == IO_ADDR) begin
                        state_d = DONE;
                        if (Mem_WE) begin
                            hex_d = MDR_wdata;
                        end else begin
                            rdata_d = SW;
                        end
                    end else begin
                        state_d = ACCESS;
                        ce_n_d  = 1'b0;
                        oe_n_d  = Mem_WE;
                        we_n_d  = !Mem_WE;
                    end
                end
            end

            ACCESS: begin
                // Runs to completion even if the request drops in the middle.
                if (cnt_q == WS_LAST) begin
                    state_d = DONE;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    if (!wr_q) begin
                        rdata_d = sram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            DONE: begin
                state_d = RELEASE;
            end

            RELEASE: begin
                // Wait for the CPU to drop its request, so that a held
                // request cannot start a second access.
                if (!req) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign R          = (state_q == DONE);
    assign Mem_rdata  = rdata_q;
    assign hex_out    = hex_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder. A transaction-level
// reference model predicts R latency, strobe activity, read data and the hex
// register. The bench also contains a simple asynchronous SRAM device.
module tb_mem_responder;

    localparam int WS = 2;
    localparam logic [15:0] IO = 16'hFFFF;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] MAR, MDR_wdata, SW;
    logic        Mem_OE, Mem_WE;
    logic [15:0] Mem_rdata, hex_out, sram_addr, sram_wdata, sram_rdata;
    logic        R, sram_ce_n, sram_oe_n, sram_we_n;

    int total = 0;
    int bad   = 0;

    // SRAM device storage.
    logic [15:0] dev_mem [0:65535];
    // Reference model storage.
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] ref_rdata = 16'h0000;
    logic [15:0] ref_hex   = 16'h0000;

    always #5 Clk = ~Clk;

    mem_responder #(
        .ADDR_W(16), .DATA_W(16), .WAIT_STATES(WS), .IO_ADDR(IO)
    ) dut (
        .Clk(Clk), .Reset(Reset), .MAR(MAR), .MDR_wdata(MDR_wdata),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .SW(SW), .Mem_rdata(Mem_rdata),
        .R(R), .hex_out(hex_out), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    function automatic logic [15:0] init_word(input logic [15:0] a);
        return (a == 16'h3000) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Asynchronous SRAM: drives data only while selected and output-enabled;
    // a write is stored while CE and WE are both low.
    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? dev_mem[sram_addr] : 16'hDEAD;

    initial begin
        for (int a = 0; a < 65536; a++) dev_mem[a] = init_word(16'(a));
        forever begin
            @(negedge Clk);
            if (!sram_ce_n && !sram_we_n) dev_mem[sram_addr] = sram_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one CPU transaction, starting at a falling edge. The request is held
    // for `hold` cycles after R is seen and then dropped.
    task automatic run_access(input bit we, input bit oe, input logic [15:0] addr,
                              input logic [15:0] data, input logic [15:0] sw, input int hold);
        bit is_io;
        int exp_lat, exp_low;
        int r_edge = -1, drop_k = -1, r_cnt = 0;
        int ce_low = 0, oe_low = 0, we_low = 0;

        is_io   = (addr == IO);
        exp_lat = is_io ? 1 : WS + 2;
        exp_low = is_io ? 0 : WS + 1;

        // Reference model: the result of the whole transaction.
        if (is_io) begin
            if (we) ref_hex = data; else ref_rdata = sw;
        end else begin
            if (we) ref_mem[addr] = data; else ref_rdata = ref_read(addr);
        end

        MAR = addr; MDR_wdata = data; SW = sw; Mem_WE = we; Mem_OE = oe;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                MAR = 16'($urandom); MDR_wdata = 16'($urandom); SW = 16'($urandom);
            end
            if (!sram_ce_n) ce_low++;
            if (!sram_oe_n) oe_low++;
            if (!sram_we_n) we_low++;
            if (R) begin
                r_cnt++;
                if (r_edge < 0) r_edge = k;
            end
            if (r_edge >= 0 && drop_k < 0 && k >= r_edge + hold) begin
                Mem_OE = 1'b0; Mem_WE = 1'b0; drop_k = k;
            end
            if (drop_k >= 0 && k >= drop_k + 1 && k >= r_edge + 2) break;
        end
        if (r_edge < 0) begin
            Mem_OE = 1'b0; Mem_WE = 1'b0;
            repeat (4) @(negedge Clk);
        end

        check("latency",  r_edge, exp_lat);
        check("r_pulses", r_cnt, 1);
        check("ce_low",   ce_low, exp_low);
        check("oe_low",   oe_low, we ? 0 : exp_low);
        check("we_low",   we_low, we ? exp_low : 0);
        check("rdata",    Mem_rdata, ref_rdata);
        check("hex",      hex_out, ref_hex);
        check("saddr",    sram_addr, addr);
        check("swdata",   sram_wdata, data);
    endtask

    initial begin
        logic [15:0] addr;
        int op;

        Reset = 1'b0; MAR = '0; MDR_wdata = '0; SW = '0; Mem_OE = 1'b0; Mem_WE = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_rdata", Mem_rdata, 16'h0);
        check("rst_r",     R, 1'b0);
        check("rst_hex",   hex_out, 16'h0);
        check("rst_strb",  {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("rst_addr",  {sram_addr, sram_wdata}, 32'h0);
        Reset = 1'b1;
        @(negedge Clk);

        // Directed cases.
        run_access(1'b0, 1'b1, 16'h3000, 16'h0000, 16'h0000, 0);   // SRAM read of BEEF
        run_access(1'b1, 1'b0, 16'h0000, 16'h1234, 16'h0000, 0);   // SRAM write at address 0
        run_access(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 0);   // read back
        run_access(1'b1, 1'b0, IO,       16'h00A5, 16'h0000, 0);   // hex write
        run_access(1'b0, 1'b1, IO,       16'h0000, 16'h03C3, 0);   // switch read
        run_access(1'b0, 1'b1, 16'h3000, 16'h0000, 16'h0000, 10);  // held request
        run_access(1'b1, 1'b1, 16'h0010, 16'hCAFE, 16'h0000, 0);   // both high: write
        run_access(1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0000, 0);
        run_access(1'b0, 1'b1, 16'hFFFE, 16'h0000, 16'h0000, 1);   // back-to-back
        run_access(1'b1, 1'b0, 16'hFFFE, 16'h5555, 16'h0000, 0);
        run_access(1'b0, 1'b1, 16'hFFFE, 16'h0000, 16'h0000, 0);

        // Randomized transactions over a small address pool.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: addr = 16'h0000;
                1: addr = 16'hFFFE;
                2: addr = IO;
                3: addr = 16'h3000;
                4: addr = 16'h0010;
                default: addr = 16'h8000 + 16'($urandom_range(0, 3));
            endcase
            op = int'($urandom_range(0, 2));
            run_access(op != 0, op != 1, addr, 16'($urandom), 16'($urandom),
                       int'($urandom_range(0, 4)));
        end

        // Reset in the middle of a write, with the counter at 1.
        MAR = 16'h7777; MDR_wdata = 16'h4242; Mem_WE = 1'b1; Mem_OE = 1'b0;
        repeat (2) @(negedge Clk);
        check("mid_we_low", sram_we_n, 1'b0);
        Reset = 1'b0;
        #1;
        check("arst_we", sram_we_n, 1'b1);
        check("arst_ce", sram_ce_n, 1'b1);
        check("arst_r",  R, 1'b0);
        check("arst_hex", hex_out, 16'h0);
        check("arst_rdata", Mem_rdata, 16'h0);
        Mem_WE = 1'b0;
        ref_rdata = 16'h0; ref_hex = 16'h0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        run_access(1'b0, 1'b1, 16'h3000, 16'h0000, 16'h0000, 0);
        run_access(1'b1, 1'b0, IO, 16'h0F0F, 16'h0000, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
